// File: rtl/ch_jitter_buffer.sv
// ch_jitter_buffer: pairs L/R input beats into stereo frames, buffers them and plays a steady L/R stream to the mixer.
// Latency: a frame written into an empty FIFO can leave at the next frame selection, one or more cycles later.
// Backpressure: never stalls upstream (frames are dropped when full); output is held stable while M_AXIS_TREADY=0.
// Optional build macro JITTER_STATS_EN adds saturating underrun_count/overflow_count outputs.
module ch_jitter_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int PREFILL    = 16
) (
  input  logic                  CH_1_S_AXIS_ACLK,
  input  logic                  ARESETN,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  playing,
  output logic                  underrun,
  output logic                  overflow
`ifdef JITTER_STATS_EN
  ,
  output logic [15:0]           underrun_count,
  output logic [15:0]           overflow_count
`else
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] START_CNT = PREFILL[DEPTH_LOG2:0];

  typedef enum logic {ST_PREFILL, ST_PLAY} state_t;

  state_t                    state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]     wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]       count;
  logic                      left_pend;
  logic [DATA_WIDTH-1:0]     left_hold, right_hold;
  logic                      in_acc, frame_in, wr_en, drop;
  logic                      frame_sel, left_done, pop, sel_underrun;
  logic [DATA_WIDTH-1:0]     sel_left, sel_right;

  assign fill_level = count;
  assign playing    = (state_q == ST_PLAY);

  // Input pairing decode: a right beat closes a frame only if a left is staged; full check uses the registered count
  always_comb begin
    in_acc   = S_AXIS_TVALID && S_AXIS_TREADY;
    frame_in = in_acc && S_AXIS_TLAST && left_pend;
    wr_en    = frame_in && (count < FULL_CNT);
    drop     = frame_in && (count >= FULL_CNT);
  end

  // Output beat events: selection on initial load or when a right beat completes; right half follows a left beat
  always_comb begin
    frame_sel = !M_AXIS_TVALID || (M_AXIS_TREADY && M_AXIS_TLAST);
    left_done = M_AXIS_TVALID && M_AXIS_TREADY && !M_AXIS_TLAST;
  end

  // Next state and frame choice, evaluated only at frame-select time
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    sel_underrun = 1'b0;
    sel_left     = '0;
    sel_right    = '0;
    if (frame_sel) begin
      case (state_q)
        ST_PREFILL: begin
          if (count >= START_CNT) begin
            state_d = ST_PLAY;
            pop     = 1'b1;
          end
        end
        ST_PLAY: begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            sel_underrun = 1'b1;
            state_d      = ST_PREFILL;
          end
        end
        default: state_d = ST_PREFILL;
      endcase
    end
    if (pop) begin
      {sel_left, sel_right} = mem[rd_ptr];
    end
  end

  // State register
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (!ARESETN) state_q <= ST_PREFILL;
    else          state_q <= state_d;
  end

  // Upstream side: ready after reset, left staging, overflow pulse
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (!ARESETN) begin
      S_AXIS_TREADY <= 1'b0;
      left_pend     <= 1'b0;
      left_hold     <= '0;
      overflow      <= 1'b0;
    end else begin
      S_AXIS_TREADY <= 1'b1;
      overflow      <= drop;
      if (in_acc) begin
        if (!S_AXIS_TLAST) begin
          left_hold <= S_AXIS_TDATA;
          left_pend <= 1'b1;
        end else begin
          left_pend <= 1'b0;
        end
      end
    end
  end

  // Frame storage; contents are don't-care until written since the pointers are reset
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr] <= {left_hold, S_AXIS_TDATA};
  end

  // FIFO pointers and frame count; simultaneous write and pop leave the count unchanged
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (wr_en && !pop)      count <= count + (DEPTH_LOG2+1)'(1);
      else if (pop && !wr_en) count <= count - (DEPTH_LOG2+1)'(1);
    end
  end

  // Mixer side: always valid after reset, left then right of the selected frame, underrun pulse
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (!ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b1;
      right_hold    <= '0;
      underrun      <= 1'b0;
    end else begin
      M_AXIS_TVALID <= 1'b1;
      underrun      <= sel_underrun;
      if (frame_sel) begin
        M_AXIS_TDATA <= sel_left;
        M_AXIS_TLAST <= 1'b0;
        right_hold   <= sel_right;
      end else if (left_done) begin
        M_AXIS_TDATA <= right_hold;
        M_AXIS_TLAST <= 1'b1;
      end
    end
  end

`ifdef JITTER_STATS_EN
  // Saturating event counters
  always_ff @(posedge CH_1_S_AXIS_ACLK) begin
    if (!ARESETN) begin
      underrun_count <= '0;
      overflow_count <= '0;
    end else begin
      if (sel_underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      if (drop && overflow_count != 16'hFFFF)         overflow_count <= overflow_count + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_ch_jitter_buffer.sv
// Bench for ch_jitter_buffer: directed stimulus with a scoreboard queue of expected mixer beats.
// The stimulus pushes expected beats before pulling them; a negedge monitor pops and compares each completed beat.
// Pulse counters for underrun/overflow are compared at phase boundaries.
module tb_ch_jitter_buffer;

  localparam int DW = 32;
  localparam int DL = 6;
  localparam int PF = 16;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_vld, s_last, s_rdy;
  logic [DW-1:0] s_dat;
  logic          m_vld, m_last, m_rdy;
  logic [DW-1:0] m_dat;
  logic [DL:0]   fill;
  logic          play, und, ovf;
`ifdef JITTER_STATS_EN
  logic [15:0]   ucnt, ocnt;
`endif

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int under_seen = 0;
  int over_seen = 0;

  always #5 clk = ~clk;

  ch_jitter_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .PREFILL(PF)) dut (
    .CH_1_S_AXIS_ACLK(clk),
    .ARESETN(rst_n),
    .S_AXIS_TVALID(s_vld),
    .S_AXIS_TDATA(s_dat),
    .S_AXIS_TLAST(s_last),
    .S_AXIS_TREADY(s_rdy),
    .M_AXIS_TVALID(m_vld),
    .M_AXIS_TDATA(m_dat),
    .M_AXIS_TLAST(m_last),
    .M_AXIS_TREADY(m_rdy),
    .fill_level(fill),
    .playing(play),
    .underrun(und),
    .overflow(ovf)
`ifdef JITTER_STATS_EN
    ,
    .underrun_count(ucnt),
    .overflow_count(ocnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.dat  = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    push_beat(l, 1'b0);
    push_beat(r, 1'b1);
  endtask

  task automatic write_beat(input logic [DW-1:0] d, input logic l);
    s_vld  = 1'b1;
    s_dat  = d;
    s_last = l;
    @(posedge clk); #1;
    s_vld  = 1'b0;
  endtask

  task automatic write_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    write_beat(l, 1'b0);
    write_beat(r, 1'b1);
  endtask

  task automatic pull(input int n);
    for (int i = 0; i < n; i++) begin
      m_rdy = 1'b1;
      @(posedge clk); #1;
    end
    m_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every completed mixer beat with the scoreboard head; count status pulses
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && m_vld === 1'b1 && m_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h/%0b expected none", m_dat, m_last);
      end else begin
        e = exp_q.pop_front();
        if (m_dat !== e.dat || m_last !== e.last) begin
          errors++;
          $display("FAIL beat: got %h/%0b expected %h/%0b", m_dat, m_last, e.dat, e.last);
        end
      end
    end
    if (rst_n === 1'b1 && und === 1'b1) under_seen++;
    if (rst_n === 1'b1 && ovf === 1'b1) over_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; s_vld = 1'b0; s_dat = '0; s_last = 1'b0; m_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 32'(s_rdy), 0);
    check("rst_m_tvalid", 32'(m_vld), 0);
    check("rst_m_tdata", m_dat, 0);
    check("rst_m_tlast", 32'(m_last), 1);
    check("rst_fill", 32'(fill), 0);
    check("rst_playing", 32'(play), 0);
    check("rst_underrun", 32'(und), 0);
    check("rst_overflow", 32'(ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_m_tvalid", 32'(m_vld), 1);
    check("post_rst_s_tready", 32'(s_rdy), 1);
    check("post_rst_first_left", 32'(m_last), 0);

    // Silence while idle in PREFILL
    for (int i = 0; i < 3; i++) push_frame('0, '0);
    pull(6);
    idle(2);
    check("idle_playing", 32'(play), 0);
    check("idle_underruns", 32'(under_seen), 0);

    // Prefill with exactly PF frames, then play them out and drain into one underrun
    for (int i = 0; i < PF; i++) write_frame(32'h00A00000 + i, 32'h00B00000 + i);
    check("prefill_fill", 32'(fill), 16);
    check("prefill_not_playing", 32'(play), 0);
    push_frame('0, '0);
    pull(2);
    check("play_start", 32'(play), 1);
    check("play_fill", 32'(fill), 15);
    for (int i = 0; i < PF; i++) push_frame(32'h00A00000 + i, 32'h00B00000 + i);
    pull(32);
    check("drain_underrun_pulse", 32'(und), 1);
    check("drain_fill", 32'(fill), 0);
    check("drain_playing", 32'(play), 0);
    push_frame('0, '0);
    push_frame('0, '0);
    pull(4);
    idle(2);
    check("drain_underruns", 32'(under_seen), 1);

    // Overflow: 70 frames into a 64-frame FIFO with the mixer stalled
    for (int i = 0; i < 70; i++) write_frame(32'h00C00000 + i, 32'h00D00000 + i);
    idle(2);
    check("ovf_fill", 32'(fill), 64);
    check("ovf_pulses", 32'(over_seen), 6);
    push_frame('0, '0);
    for (int i = 0; i < 64; i++) push_frame(32'h00C00000 + i, 32'h00D00000 + i);
    push_frame('0, '0);
    pull(132);
    idle(2);
    check("ovf_underruns", 32'(under_seen), 2);
    check("ovf_drain_fill", 32'(fill), 0);

    // Misaligned input: orphan right, replaced left, then a proper pair
    write_beat(32'h00E00001, 1'b1);
    write_beat(32'h00E00002, 1'b0);
    write_beat(32'h00E00003, 1'b0);
    write_beat(32'h00F00003, 1'b1);
    idle(1);
    check("resync_fill", 32'(fill), 1);
    for (int i = 0; i < PF - 1; i++) write_frame(32'h00E10000 + i, 32'h00F10000 + i);
    check("resync_fill16", 32'(fill), 16);
    push_frame('0, '0);
    push_frame(32'h00E00003, 32'h00F00003);
    for (int i = 0; i < PF - 1; i++) push_frame(32'h00E10000 + i, 32'h00F10000 + i);
    pull(34);
    idle(2);
    check("resync_underruns", 32'(under_seen), 3);
    check("resync_playing", 32'(play), 0);

    // Mid-stream reset with 20 frames buffered and a left beat pending
    for (int i = 0; i < 20; i++) write_frame(32'h00120000 + i, 32'h00130000 + i);
    push_frame('0, '0);
    pull(2);
    check("pre_rst_playing", 32'(play), 1);
    check("pre_rst_fill19", 32'(fill), 19);
    write_frame(32'h00120014, 32'h00130014);
    write_beat(32'h0BAD0000, 1'b0);
    check("pre_rst_fill20", 32'(fill), 20);
`ifdef JITTER_STATS_EN
    check("stats_underrun_count", 32'(ucnt), 3);
    check("stats_overflow_count", 32'(ocnt), 6);
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_fill", 32'(fill), 0);
    check("mid_rst_playing", 32'(play), 0);
    check("mid_rst_m_tvalid", 32'(m_vld), 0);
    check("mid_rst_s_tready", 32'(s_rdy), 0);
    check("mid_rst_m_tlast", 32'(m_last), 1);
`ifdef JITTER_STATS_EN
    check("mid_rst_underrun_count", 32'(ucnt), 0);
    check("mid_rst_overflow_count", 32'(ocnt), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_m_tvalid", 32'(m_vld), 1);
    check("mid_rel_s_tready", 32'(s_rdy), 1);
    write_beat(32'h0BAD0001, 1'b1);
    idle(1);
    check("mid_rel_no_partial", 32'(fill), 0);
    push_frame('0, '0);
    pull(2);
    for (int i = 0; i < PF; i++) write_frame(32'h00440000 + i, 32'h00550000 + i);
    push_frame('0, '0);
    push_frame(32'h00440000, 32'h00550000);
    pull(4);
    check("restart_playing", 32'(play), 1);
    check("restart_fill", 32'(fill), 14);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
